stat_update_reporter: RTL and testbench

// - Downstream of the running second-largest tracker: samples its dout every cycle,

---
 rtl/stat_update_reporter.sv | 170 +++++++++++++++++
 tb/tb_stat_update_reporter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_update_reporter.sv
// stat_update_reporter
// Watches the per-cycle output of the running second-largest tracker. Each value
// change becomes a {timestamp, value} record in a small FIFO. The FIFO is read by a
// slow consumer through a valid/ready stream.
//
// Optional build macro:
//   UPD_COALESCE_EN - a push into a full FIFO with no pop in the same cycle
//                     overwrites the youngest entry instead of dropping the record.
//                     The consumer therefore always ends up with the latest value.
// In both builds, a lost or overwritten record sets the sticky overflow flag.
//
// Reset: resetn is synchronous and active-low. clr is a synchronous flush.
module stat_update_reporter #(
   parameter int DATA_WIDTH = 32,
   parameter int TS_WIDTH   = 16,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [DATA_WIDTH-1:0]    stat_in,
   input  logic                     clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_value,
   output logic [TS_WIDTH-1:0]      out_ts,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);        // FIFO index width
   localparam int PW = AW + 1;               // pointer width incl. wrap bit
   localparam int EW = TS_WIDTH + DATA_WIDTH; // record width {ts, value}

   typedef logic [EW-1:0] entry_t;

   // state
   entry_t                 mem_q [DEPTH];
   entry_t                 mem_d [DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [TS_WIDTH-1:0]    ts_q, ts_d;
   logic [DATA_WIDTH-1:0]  prev_q, prev_d;
   logic                   overflow_q, overflow_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]  out_value_q, out_value_d;
   logic [TS_WIDTH-1:0]    out_ts_q, out_ts_d;
   logic [PW-1:0]          level_q, level_d;

   // per-cycle decode
   entry_t                 entry_s;
   entry_t                 head_s;
   logic                   change_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   full_s;
`ifdef UPD_COALESCE_EN
   logic [AW-1:0]          last_idx_s;
`endif

   // Build the candidate record and classify this cycle's push/pop/full conditions
   always_comb begin
      entry_s  = {ts_q, stat_in};
      change_s = (stat_in != prev_q);
      push_s   = change_s & ~clr;
      // out_valid_q mirrors "FIFO non-empty", so a pop never happens on empty
      pop_s    = out_valid_q & out_ready & ~clr;
      // Full when the indices match but the wrap bits differ
      full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   end

`ifdef UPD_COALESCE_EN
   // Index of the youngest entry, which is the one overwritten when coalescing
   always_comb begin
      last_idx_s = wr_ptr_q[AW-1:0] - AW'(1);
   end
`endif

   // Next-state logic for timestamp, change detector, FIFO and registered outputs
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      ts_d       = ts_q + TS_WIDTH'(1);
      // prev follows stat_in every cycle, including clr cycles
      prev_d     = stat_in;

      if (clr) begin
         wr_ptr_d   = {PW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         overflow_d = 1'b0;
      end else begin
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         if (push_s) begin
            if (!full_s || pop_s) begin
               // A pop in the same cycle frees the slot, so the write reuses it
               mem_d[wr_ptr_q[AW-1:0]] = entry_s;
               wr_ptr_d                = wr_ptr_q + PW'(1);
            end else begin
               overflow_d = 1'b1;
`ifdef UPD_COALESCE_EN
               // DEPTH >= 2, so the youngest entry is never the head
               mem_d[last_idx_s] = entry_s;
`else
               // Drop the new record and leave the queued entries unchanged
               wr_ptr_d = wr_ptr_q;
`endif
            end
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
      end

      level_d     = wr_ptr_d - rd_ptr_d;
      out_valid_d = (level_d != {PW{1'b0}});
      head_s      = mem_d[rd_ptr_d[AW-1:0]];
      if (out_valid_d) begin
         out_ts_d    = head_s[EW-1:DATA_WIDTH];
         out_value_d = head_s[DATA_WIDTH-1:0];
      end else begin
         // Contents are don't-care while empty; hold the last values to avoid toggling
         out_ts_d    = out_ts_q;
         out_value_d = out_value_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {EW{1'b0}};
         end
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         ts_q        <= {TS_WIDTH{1'b0}};
         prev_q      <= {DATA_WIDTH{1'b0}};
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_value_q <= {DATA_WIDTH{1'b0}};
         out_ts_q    <= {TS_WIDTH{1'b0}};
         level_q     <= {PW{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ts_q        <= ts_d;
         prev_q      <= prev_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         out_value_q <= out_value_d;
         out_ts_q    <= out_ts_d;
         level_q     <= level_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_value = out_value_q;
   assign out_ts    = out_ts_q;
   assign overflow  = overflow_q;
   assign level     = level_q;

endmodule

// File: tb/tb_stat_update_reporter.sv
// Self-checking bench for stat_update_reporter (DEPTH=4, TS_WIDTH=4 so wrap is reachable).
// Reference model: a queue of {ts, value} records plus a cycle counter.
module tb_stat_update_reporter;

   localparam int DW  = 32;
   localparam int TSW = 4;
   localparam int DEP = 4;

   typedef struct {
      logic [TSW-1:0] ts;
      logic [DW-1:0]  val;
   } rec_t;

   logic            clk = 1'b0;
   logic            resetn;
   logic [DW-1:0]   stat_in;
   logic            clr;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_value;
   logic [TSW-1:0]  out_ts;
   logic            overflow;
   logic [2:0]      level;

   int total = 0;
   int bad   = 0;

   // reference model state
   rec_t           mq[$];
   logic [TSW-1:0] m_ts;
   logic [DW-1:0]  m_prev;
   logic           m_ovf;

   stat_update_reporter #(.DATA_WIDTH(DW), .TS_WIDTH(TSW), .DEPTH(DEP)) dut (
      .clk(clk), .resetn(resetn), .stat_in(stat_in), .clr(clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
      .out_ts(out_ts), .overflow(overflow), .level(level)
   );

   always #5 clk = ~clk;

   // One clock cycle: drive the inputs, advance the model, then wait past the edge
   task automatic step(input logic rn, input logic [DW-1:0] s, input logic c, input logic r);
      rec_t rec;
      bit   full, pop;
      resetn = rn; stat_in = s; clr = c; out_ready = r;
      if (!rn) begin
         mq.delete(); m_ts = '0; m_prev = '0; m_ovf = 1'b0;
      end else if (c) begin
         mq.delete(); m_ovf = 1'b0; m_prev = s; m_ts = m_ts + 4'd1;
      end else begin
         full = (mq.size() == DEP);
         pop  = (mq.size() != 0) && r;
         if (pop) void'(mq.pop_front());
         if (s != m_prev) begin
            rec.ts = m_ts; rec.val = s;
            if (!full || pop) mq.push_back(rec);
            else begin
               m_ovf = 1'b1;
`ifdef UPD_COALESCE_EN
               mq[mq.size()-1] = rec;
`endif
            end
         end
         m_prev = s; m_ts = m_ts + 4'd1;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (out_value !== 32'd0 || out_ts !== 4'd0) begin
         bad++; $display("FAIL reset_data: value=%0d ts=%0d want 0/0", out_value, out_ts);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b1, '0, 1'b0, 1'b0);
         total++;
         if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset_idle: valid=%b level=%0d ovf=%b want 0/0/0", out_valid, level, overflow);
         end
      end
   endtask

   task automatic test_latency();
      do_reset();
      for (int c = 0; c < 3; c++) step(1'b1, '0, 1'b0, 1'b1);
      step(1'b1, 32'd5, 1'b0, 1'b1);       // change in cycle 3
      total++;
      if (out_valid !== 1'b1 || out_value !== 32'd5 || out_ts !== 4'd3) begin
         bad++; $display("FAIL latency: valid=%b value=%0d ts=%0d want 1/5/3", out_valid, out_value, out_ts);
      end
      step(1'b1, 32'd5, 1'b0, 1'b1);       // popped at this edge
      total++;
      if (out_valid !== 1'b0 || level !== 3'd0) begin
         bad++; $display("FAIL latency_pop: valid=%b level=%0d want 0/0", out_valid, level);
      end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] exp_vals [4];
`ifdef UPD_COALESCE_EN
      exp_vals = '{32'd1, 32'd2, 32'd3, 32'd6};
`else
      exp_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
`endif
      do_reset();
      for (int v = 1; v <= 6; v++) step(1'b1, DW'(v), 1'b0, 1'b0);
      total++;
      if (level !== 3'd4 || overflow !== 1'b1) begin
         bad++; $display("FAIL overflow_fill: level=%0d ovf=%b want 4/1", level, overflow);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_value !== exp_vals[i]) begin
            bad++; $display("FAIL overflow_drain%0d: valid=%b value=%0d want 1/%0d", i, out_valid, out_value, exp_vals[i]);
         end
         step(1'b1, 32'd6, 1'b0, 1'b1);
      end
      total++;
      if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b1) begin
         bad++; $display("FAIL overflow_empty: valid=%b level=%0d ovf=%b want 0/0/1", out_valid, level, overflow);
      end
   endtask

   task automatic test_full_pop();
      logic [DW-1:0] exp_vals [4];
      exp_vals = '{32'd2, 32'd3, 32'd4, 32'd7};
      do_reset();
      for (int v = 1; v <= 4; v++) step(1'b1, DW'(v), 1'b0, 1'b0);
      step(1'b1, 32'd7, 1'b0, 1'b1);       // push and pop while full
      total++;
      if (level !== 3'd4 || overflow !== 1'b0) begin
         bad++; $display("FAIL full_pop: level=%0d ovf=%b want 4/0", level, overflow);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_value !== exp_vals[i]) begin
            bad++; $display("FAIL full_pop_drain%0d: valid=%b value=%0d want 1/%0d", i, out_valid, out_value, exp_vals[i]);
         end
         step(1'b1, 32'd7, 1'b0, 1'b1);
      end
   endtask

   task automatic test_hold_clr();
      logic [DW-1:0] v0;
      logic [TSW-1:0] t0;
      do_reset();
      step(1'b1, 32'd9, 1'b0, 1'b0);       // record {0, 9}
      for (int v = 1; v <= 4; v++) step(1'b1, DW'(v), 1'b0, 1'b0);
      v0 = out_value; t0 = out_ts;
      total++;
      if (v0 !== 32'd9 || t0 !== 4'd0 || overflow !== 1'b1) begin
         bad++; $display("FAIL hold_head: value=%0d ts=%0d ovf=%b want 9/0/1", v0, t0, overflow);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'd4, 1'b0, 1'b0);
         total++;
         if (out_valid !== 1'b1 || out_value !== 32'd9 || out_ts !== 4'd0) begin
            bad++; $display("FAIL hold_stable: valid=%b value=%0d ts=%0d want 1/9/0", out_valid, out_value, out_ts);
         end
      end
      step(1'b1, 32'd8, 1'b1, 1'b1);       // clr with change and ready: both ignored
      total++;
      if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
         bad++; $display("FAIL clr: valid=%b level=%0d ovf=%b want 0/0/0", out_valid, level, overflow);
      end
      step(1'b1, 32'd8, 1'b0, 1'b0);       // prev was loaded during clr: no record
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL clr_prev: valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_ts_wrap_reset();
      do_reset();
      for (int c = 0; c < 17; c++) step(1'b1, '0, 1'b0, 1'b0);
      step(1'b1, 32'd3, 1'b0, 1'b0);       // cycle 17 -> ts 1
      total++;
      if (out_valid !== 1'b1 || out_ts !== 4'd1 || out_value !== 32'd3) begin
         bad++; $display("FAIL ts_wrap: valid=%b ts=%0d value=%0d want 1/1/3", out_valid, out_ts, out_value);
      end
      step(1'b1, 32'd4, 1'b0, 1'b0);
      step(1'b1, 32'd5, 1'b0, 1'b0);
      total++;
      if (level !== 3'd3) begin
         bad++; $display("FAIL pre_reset_level: level=%0d want 3", level);
      end
      step(1'b0, 32'd5, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
         bad++; $display("FAIL mid_reset: valid=%b level=%0d ovf=%b want 0/0/0", out_valid, level, overflow);
      end
      step(1'b1, 32'd7, 1'b0, 1'b0);       // first cycle after reset: ts 0
      total++;
      if (out_valid !== 1'b1 || out_ts !== 4'd0 || out_value !== 32'd7) begin
         bad++; $display("FAIL ts_restart: valid=%b ts=%0d value=%0d want 1/0/7", out_valid, out_ts, out_value);
      end
   endtask

   task automatic test_random();
      logic          rn, c, r;
      logic [DW-1:0] s;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rn = ($urandom_range(0, 99) != 0);
         c  = ($urandom_range(0, 24) == 0);
         r  = ($urandom_range(0, 2) == 0);
         s  = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 5)) : stat_in;
         step(rn, s, c, r);
         total++;
         if (out_valid !== (mq.size() != 0) || level !== 3'(mq.size()) || overflow !== m_ovf) begin
            bad++; $display("FAIL rand_ctl%0d: valid=%b level=%0d ovf=%b want %b/%0d/%b",
                            i, out_valid, level, overflow, (mq.size() != 0), mq.size(), m_ovf);
         end
         if (mq.size() != 0) begin
            total++;
            if (out_value !== mq[0].val || out_ts !== mq[0].ts) begin
               bad++; $display("FAIL rand_head%0d: value=%0d ts=%0d want %0d/%0d",
                               i, out_value, out_ts, mq[0].val, mq[0].ts);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      // change every cycle with ready held: each record passes straight through
      for (int i = 0; i < 20; i++) begin
         step(1'b1, DW'(i + 1), 1'b0, 1'b1);
         total++;
         if (out_valid !== 1'b1 || out_value !== DW'(i + 1) || out_ts !== TSW'(i) || level !== 3'd1) begin
            bad++; $display("FAIL b2b%0d: valid=%b value=%0d ts=%0d level=%0d want 1/%0d/%0d/1",
                            i, out_valid, out_value, out_ts, level, i + 1, TSW'(i));
         end
      end
   endtask

   initial begin
      resetn = 1'b0; stat_in = '0; clr = 1'b0; out_ready = 1'b0;
      m_ts = '0; m_prev = '0; m_ovf = 1'b0;
      test_reset();
      test_latency();
      test_overflow();
      test_full_pop();
      test_hold_clr();
      test_ts_wrap_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
